eip_unit: RTL and testbench

- Parametrised instruction-pointer unit; successor to the fixed 32-bit multi-clock eip register.
- Single clock; one command per cycle: sequential advance by instruction length, absolute jump, PC-relative branch, call/return through an internal return-address stack (RAS), direct write.
- Sits between decode and the fetch address mux.
- Illegal commands drive a HALT state that freezes eip until resume.

---
 rtl/eip_if.sv | 39 +++
 rtl/eip_unit.sv | 166 ++++++++++++++++
 tb/tb_eip_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/eip_if.sv
// Command/status bundle between decode and the instruction-pointer unit.
// EIP_PREV_EN adds prev_eip to the status side.
interface eip_if #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 4,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              op_valid;
    logic [2:0]        op;
    logic [LEN_W-1:0]  num_of_ope;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] offset;
    logic              resume;
    logic [ADDR_W-1:0] eip;
    logic              halted;
    logic [1:0]        fault_code;
    logic [CNT_W-1:0]  ras_count;
`ifdef EIP_PREV_EN
    logic [ADDR_W-1:0] prev_eip;
`endif

    modport master (
        output op_valid, op, num_of_ope, target, offset, resume,
        input  eip, halted, fault_code, ras_count
`ifdef EIP_PREV_EN
        , input prev_eip
`endif
    );

    modport slave (
        input  op_valid, op, num_of_ope, target, offset, resume,
        output eip, halted, fault_code, ras_count
`ifdef EIP_PREV_EN
        , output prev_eip
`endif
    );
endinterface

// File: rtl/eip_unit.sv
// Instruction-pointer unit: SEQ/JMP/BRA/CALL/RET/WR with a circular return-address stack
// and a HALT state on illegal commands. Optional macro EIP_PREV_EN adds prev_eip.
module eip_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h00000027,
    parameter int          LEN_W     = 4,
    parameter int          MAX_LEN   = 6,
    parameter int          RAS_DEPTH = 4
) (
    input logic  clock,
    input logic  reset,
    eip_if.slave bus
);
    localparam int                PTR_W   = $clog2(RAS_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] RST_EIP = ADDR_W'(RESET_VEC);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_SEQ  = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_BRA  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_WR   = 3'd6;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_eip;
    logic [1:0]        r_fault;
    logic [CNT_W-1:0]  r_ras_count;
    logic [PTR_W-1:0]  r_ras_ptr;
    logic [ADDR_W-1:0] r_ras_mem [RAS_DEPTH];

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_eip_nxt;
    logic [1:0]        w_fault_nxt;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_len_ext;
    logic [ADDR_W-1:0] w_seq_addr;
    logic              w_len_bad;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic [PTR_W-1:0]  w_top_idx;
`ifdef EIP_PREV_EN
    logic              w_prev_load;
    logic [ADDR_W-1:0] r_prev_eip;
`endif

    assign w_len_ext   = ADDR_W'(bus.num_of_ope);
    assign w_seq_addr  = r_eip + w_len_ext;
    assign w_len_bad   = (bus.num_of_ope == '0) || (bus.num_of_ope > LEN_W'(MAX_LEN));
    assign w_ras_empty = (r_ras_count == '0);
    assign w_ras_full  = (r_ras_count == CNT_W'(RAS_DEPTH));
    assign w_top_idx   = r_ras_ptr - PTR_W'(1);

    // Next-state decode: only RUN with a valid command changes architectural state.
    always_comb begin
        w_state_nxt = r_state;
        w_eip_nxt   = r_eip;
        w_fault_nxt = r_fault;
        w_push      = 1'b0;
        w_pop       = 1'b0;
`ifdef EIP_PREV_EN
        w_prev_load = 1'b0;
`endif
        case (r_state)
            ST_RUN: begin
                if (bus.op_valid) begin
                    case (bus.op)
                        OP_NOP: ;
                        OP_SEQ, OP_BRA, OP_CALL: begin
                            if (w_len_bad) begin
                                w_fault_nxt = 2'd1;
                                w_state_nxt = ST_HALT;
                            end else if (bus.op == OP_SEQ) begin
                                w_eip_nxt = w_seq_addr;
                            end else if (bus.op == OP_BRA) begin
                                w_eip_nxt = w_seq_addr + bus.offset;
                            end else begin
                                w_eip_nxt = bus.target;
                                w_push    = 1'b1;
                            end
`ifdef EIP_PREV_EN
                            w_prev_load = !w_len_bad;
`endif
                        end
                        OP_JMP, OP_WR: begin
                            w_eip_nxt = bus.target;
`ifdef EIP_PREV_EN
                            w_prev_load = 1'b1;
`endif
                        end
                        OP_RET: begin
                            if (w_ras_empty) begin
                                w_fault_nxt = 2'd2;
                                w_state_nxt = ST_HALT;
                            end else begin
                                w_eip_nxt = r_ras_mem[w_top_idx];
                                w_pop     = 1'b1;
`ifdef EIP_PREV_EN
                                w_prev_load = 1'b1;
`endif
                            end
                        end
                        default: begin
                            w_fault_nxt = 2'd3;
                            w_state_nxt = ST_HALT;
                        end
                    endcase
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    w_state_nxt = ST_RUN;
                    w_fault_nxt = 2'd0;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // A push at full wraps the pointer onto the oldest entry, so the count saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_eip       <= RST_EIP;
            r_fault     <= 2'd0;
            r_ras_count <= '0;
            r_ras_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_eip   <= w_eip_nxt;
            r_fault <= w_fault_nxt;
            if (w_push) begin
                r_ras_ptr <= r_ras_ptr + PTR_W'(1);
                if (!w_ras_full)
                    r_ras_count <= r_ras_count + CNT_W'(1);
            end else if (w_pop) begin
                r_ras_ptr   <= w_top_idx;
                r_ras_count <= r_ras_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_ras_mem[r_ras_ptr] <= w_seq_addr;
    end

`ifdef EIP_PREV_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_prev_eip <= RST_EIP;
        else if (w_prev_load)
            r_prev_eip <= r_eip;
    end
    assign bus.prev_eip = r_prev_eip;
`endif

    assign bus.eip        = r_eip;
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.fault_code = r_fault;
    assign bus.ras_count  = r_ras_count;
endmodule

// File: tb/tb_eip_unit.sv
// Directed bench for eip_unit: one task per scenario, expected values computed by hand.
module tb_eip_unit;
    logic clock;
    logic reset;
    int   testsRun    = 0;
    int   testsFailed = 0;

    eip_if #(.ADDR_W(32), .LEN_W(4), .RAS_DEPTH(4)) bus ();

    eip_unit #(
        .ADDR_W(32), .RESET_VEC(32'h00000027), .LEN_W(4), .MAX_LEN(6), .RAS_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one command on the falling edge, let it be sampled, then look 1 ns after the edge.
    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [3:0] len,
                                 input logic [31:0] tgt, input logic [31:0] off, input logic res);
        @(negedge clock);
        bus.op_valid   = valid;
        bus.op         = op;
        bus.num_of_ope = len;
        bus.target     = tgt;
        bus.offset     = off;
        bus.resume     = res;
        @(posedge clock);
        #1;
        bus.op_valid = 1'b0;
        bus.resume   = 1'b0;
    endtask

    task automatic doResume();
        applyStimulus(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        testsRun++; if (bus.eip !== 32'h27) begin testsFailed++; $display("[TB] FAIL reset_eip got %h want %h", bus.eip, 32'h27); end
        testsRun++; if (bus.halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_halted got %b want 0", bus.halted); end
        testsRun++; if (bus.fault_code !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_fault got %0d want 0", bus.fault_code); end
        testsRun++; if (bus.ras_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_ras got %0d want 0", bus.ras_count); end
`ifdef EIP_PREV_EN
        testsRun++; if (bus.prev_eip !== 32'h27) begin testsFailed++; $display("[TB] FAIL reset_prev got %h want %h", bus.prev_eip, 32'h27); end
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_seq();
        applyStimulus(1'b1, 3'd1, 4'd3, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h2A) begin testsFailed++; $display("[TB] FAIL seq3 got %h want %h", bus.eip, 32'h2A); end
        applyStimulus(1'b1, 3'd1, 4'd6, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h30) begin testsFailed++; $display("[TB] FAIL seq6 got %h want %h", bus.eip, 32'h30); end
        testsRun++; if (bus.halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL seq_halted got %b want 0", bus.halted); end
`ifdef EIP_PREV_EN
        testsRun++; if (bus.prev_eip !== 32'h2A) begin testsFailed++; $display("[TB] FAIL seq_prev got %h want %h", bus.prev_eip, 32'h2A); end
`endif
        applyStimulus(1'b0, 3'd2, 4'd1, 32'h500, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h30) begin testsFailed++; $display("[TB] FAIL invalid_jmp got %h want %h", bus.eip, 32'h30); end
        applyStimulus(1'b1, 3'd0, 4'd1, 32'h500, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h30) begin testsFailed++; $display("[TB] FAIL nop got %h want %h", bus.eip, 32'h30); end
    endtask

    task automatic test_call_ret();
        applyStimulus(1'b1, 3'd4, 4'd2, 32'h100, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h100) begin testsFailed++; $display("[TB] FAIL call_eip got %h want %h", bus.eip, 32'h100); end
        testsRun++; if (bus.ras_count !== 3'd1) begin testsFailed++; $display("[TB] FAIL call_ras got %0d want 1", bus.ras_count); end
        applyStimulus(1'b1, 3'd1, 4'd1, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h101) begin testsFailed++; $display("[TB] FAIL call_seq got %h want %h", bus.eip, 32'h101); end
        testsRun++; if (bus.ras_count !== 3'd1) begin testsFailed++; $display("[TB] FAIL call_seq_ras got %0d want 1", bus.ras_count); end
        applyStimulus(1'b1, 3'd5, 4'd0, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h32) begin testsFailed++; $display("[TB] FAIL ret_eip got %h want %h", bus.eip, 32'h32); end
        testsRun++; if (bus.ras_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL ret_ras got %0d want 0", bus.ras_count); end
`ifdef EIP_PREV_EN
        testsRun++; if (bus.prev_eip !== 32'h101) begin testsFailed++; $display("[TB] FAIL ret_prev got %h want %h", bus.prev_eip, 32'h101); end
`endif
    endtask

    task automatic test_wrap();
        applyStimulus(1'b1, 3'd6, 4'd0, 32'hFFFFFFFE, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'hFFFFFFFE) begin testsFailed++; $display("[TB] FAIL wr got %h want %h", bus.eip, 32'hFFFFFFFE); end
        applyStimulus(1'b1, 3'd1, 4'd4, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h2) begin testsFailed++; $display("[TB] FAIL wrap_seq got %h want %h", bus.eip, 32'h2); end
        applyStimulus(1'b1, 3'd3, 4'd2, 32'h0, 32'hFFFFFFF0, 1'b0);
        testsRun++; if (bus.eip !== 32'hFFFFFFF4) begin testsFailed++; $display("[TB] FAIL bra_neg got %h want %h", bus.eip, 32'hFFFFFFF4); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] retAddr [5] = '{32'h1001, 32'h2002, 32'h3003, 32'h4004, 32'h5005};
        logic [31:0] callTgt [5] = '{32'h2000, 32'h3000, 32'h4000, 32'h5000, 32'h6000};
        applyStimulus(1'b1, 3'd2, 4'd0, 32'h1000, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 3'd4, 4'(i + 1), callTgt[i], 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h6000) begin testsFailed++; $display("[TB] FAIL ovf_eip got %h want %h", bus.eip, 32'h6000); end
        testsRun++; if (bus.ras_count !== 3'd4) begin testsFailed++; $display("[TB] FAIL ovf_ras got %0d want 4", bus.ras_count); end
        for (int i = 4; i >= 1; i--) begin
            applyStimulus(1'b1, 3'd5, 4'd0, 32'h0, 32'h0, 1'b0);
            testsRun++; if (bus.eip !== retAddr[i]) begin testsFailed++; $display("[TB] FAIL ovf_ret%0d got %h want %h", i, bus.eip, retAddr[i]); end
        end
        testsRun++; if (bus.ras_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL ovf_empty got %0d want 0", bus.ras_count); end
        applyStimulus(1'b1, 3'd5, 4'd0, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.fault_code !== 2'd2) begin testsFailed++; $display("[TB] FAIL underflow_fault got %0d want 2", bus.fault_code); end
        testsRun++; if (bus.halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL underflow_halted got %b want 1", bus.halted); end
        testsRun++; if (bus.eip !== 32'h2002) begin testsFailed++; $display("[TB] FAIL underflow_eip got %h want %h", bus.eip, 32'h2002); end
        applyStimulus(1'b1, 3'd2, 4'd0, 32'h9000, 32'h0, 1'b1);
        testsRun++; if (bus.halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL resume_cmd_halted got %b want 0", bus.halted); end
        testsRun++; if (bus.eip !== 32'h2002) begin testsFailed++; $display("[TB] FAIL resume_cmd_eip got %h want %h", bus.eip, 32'h2002); end
    endtask

    task automatic test_bad_len();
        applyStimulus(1'b1, 3'd1, 4'd0, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL len0_halted got %b want 1", bus.halted); end
        testsRun++; if (bus.fault_code !== 2'd1) begin testsFailed++; $display("[TB] FAIL len0_fault got %0d want 1", bus.fault_code); end
        testsRun++; if (bus.eip !== 32'h2002) begin testsFailed++; $display("[TB] FAIL len0_eip got %h want %h", bus.eip, 32'h2002); end
        applyStimulus(1'b1, 3'd2, 4'd0, 32'h200, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h2002) begin testsFailed++; $display("[TB] FAIL halt_jmp got %h want %h", bus.eip, 32'h2002); end
        doResume();
        testsRun++; if (bus.halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL resume_halted got %b want 0", bus.halted); end
        testsRun++; if (bus.fault_code !== 2'd0) begin testsFailed++; $display("[TB] FAIL resume_fault got %0d want 0", bus.fault_code); end
        applyStimulus(1'b1, 3'd2, 4'd0, 32'h200, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h200) begin testsFailed++; $display("[TB] FAIL jmp got %h want %h", bus.eip, 32'h200); end
        applyStimulus(1'b1, 3'd1, 4'd6, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.eip !== 32'h206) begin testsFailed++; $display("[TB] FAIL len_max got %h want %h", bus.eip, 32'h206); end
        applyStimulus(1'b1, 3'd4, 4'd7, 32'h800, 32'h0, 1'b0);
        testsRun++; if (bus.fault_code !== 2'd1) begin testsFailed++; $display("[TB] FAIL len7_fault got %0d want 1", bus.fault_code); end
        testsRun++; if (bus.ras_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL len7_ras got %0d want 0", bus.ras_count); end
        testsRun++; if (bus.eip !== 32'h206) begin testsFailed++; $display("[TB] FAIL len7_eip got %h want %h", bus.eip, 32'h206); end
        doResume();
        applyStimulus(1'b1, 3'd7, 4'd1, 32'h0, 32'h0, 1'b1);
        testsRun++; if (bus.fault_code !== 2'd3) begin testsFailed++; $display("[TB] FAIL reserved_fault got %0d want 3", bus.fault_code); end
        testsRun++; if (bus.halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL reserved_halted got %b want 1", bus.halted); end
        doResume();
    endtask

    task automatic test_reset_mid_halt();
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 3'd4, 4'd1, 32'h300, 32'h0, 1'b0);
        testsRun++; if (bus.ras_count !== 3'd3) begin testsFailed++; $display("[TB] FAIL pre_reset_ras got %0d want 3", bus.ras_count); end
        applyStimulus(1'b1, 3'd7, 4'd0, 32'h0, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        testsRun++; if (bus.eip !== 32'h27) begin testsFailed++; $display("[TB] FAIL async_eip got %h want %h", bus.eip, 32'h27); end
        testsRun++; if (bus.halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_halted got %b want 0", bus.halted); end
        testsRun++; if (bus.ras_count !== 3'd0) begin testsFailed++; $display("[TB] FAIL async_ras got %0d want 0", bus.ras_count); end
`ifdef EIP_PREV_EN
        testsRun++; if (bus.prev_eip !== 32'h27) begin testsFailed++; $display("[TB] FAIL async_prev got %h want %h", bus.prev_eip, 32'h27); end
`endif
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b1, 3'd5, 4'd0, 32'h0, 32'h0, 1'b0);
        testsRun++; if (bus.fault_code !== 2'd2) begin testsFailed++; $display("[TB] FAIL post_reset_ret got %0d want 2", bus.fault_code); end
    endtask

    initial begin
        bus.op_valid   = 1'b0;
        bus.op         = 3'd0;
        bus.num_of_ope = 4'd0;
        bus.target     = 32'h0;
        bus.offset     = 32'h0;
        bus.resume     = 1'b0;
        test_reset();
        test_seq();
        test_call_ret();
        test_wrap();
        test_ras_overflow();
        test_bad_len();
        test_reset_mid_halt();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
